// File: rtl/uparc_sysmem_resp_if.sv
// I-Port / D-Port bus between a CPU initiator (master) and a memory responder (slave).
interface uparc_sysmem_resp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   i_IAddr;
    logic                    i_IRdC;
    logic [DATA_WIDTH-1:0]   o_IData;
    logic                    o_IRdy;
    logic                    o_IErr;
    logic [ADDR_WIDTH-1:0]   i_DAddr;
    logic                    i_DCmd;
    logic                    i_DRnW;
    logic [DATA_WIDTH/8-1:0] i_DBen;
    logic [DATA_WIDTH-1:0]   i_DData;
    logic [DATA_WIDTH-1:0]   o_DData;
    logic                    o_DRdy;
    logic                    o_DErr;

    modport master (
        output i_IAddr, i_IRdC, i_DAddr, i_DCmd, i_DRnW, i_DBen, i_DData,
        input  o_IData, o_IRdy, o_IErr, o_DData, o_DRdy, o_DErr
    );

    modport slave (
        input  i_IAddr, i_IRdC, i_DAddr, i_DCmd, i_DRnW, i_DBen, i_DData,
        output o_IData, o_IRdy, o_IErr, o_DData, o_DRdy, o_DErr
    );
endinterface

// File: rtl/uparc_sysmem_resp.sv
// On-chip word memory answering the CPU I-Port and D-Port with round-robin arbitration.
// Define UPARC_SYSMEM_ERR_EN to enable alignment/range bus errors; otherwise addresses alias.
module uparc_sysmem_resp #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uparc_sysmem_resp_if.slave   bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int BEN_W = DATA_WIDTH / 8;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg, state_next;
    logic                    last_d_reg, last_d_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic                    accept, grant_d;
    logic                    gnt_d_reg, rnw_reg, err_reg;
    logic [IDX_W-1:0]        idx_reg, rd_idx;
    logic [BEN_W-1:0]        ben_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg, rd_data_reg;
    logic                    we, resp;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

    // Index 0 decodes the I-Port, index 1 the D-Port.
    logic [1:0][ADDR_WIDTH-1:0] req_addr;
    logic [1:0][IDX_W-1:0]      req_idx;
    logic [1:0]                 req_err;

    assign req_addr[0] = bus.i_IAddr;
    assign req_addr[1] = bus.i_DAddr;

`ifdef UPARC_SYSMEM_ERR_EN
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * MEM_WORDS);
`else
    logic unused_base;
    assign unused_base = &{1'b0, BASE_ADDR};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
`ifdef UPARC_SYSMEM_ERR_EN
            logic [ADDR_WIDTH-1:0] offset;
            logic                  unused_offset;
            assign offset          = req_addr[gi] - BASE_ADDR;
            assign req_idx[gi]     = offset[IDX_W+1:2];
            assign req_err[gi]     = (req_addr[gi][1:0] != 2'b00) || (req_addr[gi] < BASE_ADDR) ||
                                     ({1'b0, req_addr[gi]} >= ADDR_LIMIT);
            assign unused_offset   = &{1'b0, offset};
`else
            logic unused_addr;
            assign req_idx[gi]  = req_addr[gi][IDX_W+1:2];
            assign req_err[gi]  = 1'b0;
            assign unused_addr  = &{1'b0, req_addr[gi]};
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            last_d_reg <= 1'b0;
            cnt_reg    <= 4'd0;
            gnt_d_reg  <= 1'b0;
            rnw_reg    <= 1'b0;
            err_reg    <= 1'b0;
            idx_reg    <= '0;
            ben_reg    <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            last_d_reg <= last_d_next;
            cnt_reg    <= cnt_next;
            if (accept) begin
                gnt_d_reg <= grant_d;
                rnw_reg   <= grant_d ? bus.i_DRnW : 1'b1;
                err_reg   <= grant_d ? req_err[1] : req_err[0];
                idx_reg   <= grant_d ? req_idx[1] : req_idx[0];
                ben_reg   <= bus.i_DBen;
                wdata_reg <= bus.i_DData;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        last_d_next = last_d_reg;
        cnt_next    = cnt_reg;
        accept      = 1'b0;
        grant_d     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.i_IRdC || bus.i_DCmd) begin
                    accept  = 1'b1;
                    grant_d = bus.i_DCmd && (!bus.i_IRdC || !last_d_reg);
                    // Round-robin pointer only moves when both ports contend.
                    if (bus.i_IRdC && bus.i_DCmd)
                        last_d_next = grant_d;
                    cnt_next   = WS_LOAD;
                    state_next = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) state_next = RESP;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read address follows the incoming request while idle so zero-wait reads are ready in RESP.
    assign rd_idx = (state_reg == IDLE) ? (grant_d ? req_idx[1] : req_idx[0]) : idx_reg;
    assign resp   = (state_reg == RESP);
    assign we     = resp && gnt_d_reg && !rnw_reg && !err_reg && !rst;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BEN_W; b++) begin
                if (ben_reg[b]) mem[idx_reg][b*8 +: 8] <= wdata_reg[b*8 +: 8];
            end
        end
        rd_data_reg <= mem[rd_idx];
    end

    assign bus.o_IRdy  = resp && !gnt_d_reg;
    assign bus.o_DRdy  = resp && gnt_d_reg;
`ifdef UPARC_SYSMEM_ERR_EN
    assign bus.o_IErr  = bus.o_IRdy && err_reg;
    assign bus.o_DErr  = bus.o_DRdy && err_reg;
`else
    assign bus.o_IErr  = 1'b0;
    assign bus.o_DErr  = 1'b0;
`endif
    assign bus.o_IData = (bus.o_IRdy && !err_reg) ? rd_data_reg : '0;
    assign bus.o_DData = (bus.o_DRdy && rnw_reg && !err_reg) ? rd_data_reg : '0;

endmodule

// File: tb/tb_uparc_sysmem_resp.sv
// Bench for uparc_sysmem_resp: table of single transactions plus arbitration, reset and zero-wait sequences.
module tb_uparc_sysmem_resp;
`ifdef UPARC_SYSMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] BASE0 = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uparc_sysmem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
    uparc_sysmem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

    uparc_sysmem_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(4096),
                        .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    uparc_sysmem_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(4096),
                        .BASE_ADDR(BASE0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        bit          rnw;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    exp_t q1[$];
    exp_t q0[$];
    vec_t vecs[$];

    task automatic push_exp(input int u, input bit is_d, input logic [31:0] d, input bit e, input int c);
        exp_t x;
        x.is_d = is_d; x.data = d; x.err = e; x.cyc = c;
        if (u == 1) q1.push_back(x);
        else        q0.push_back(x);
    endtask

    task automatic mon(input int u, input bit irdy, input bit drdy, input logic [31:0] idata,
                       input logic [31:0] ddata, input bit ierr, input bit derr);
        exp_t e;
        logic [31:0] ad;
        bit          ae;
        if (irdy && drdy) begin
            vectors++; miscompares++;
            $display("FAIL both_rdy dut%0d cyc=%0d: IRdy=1 DRdy=1, required at most one", u, cyc);
        end
        if (irdy || drdy) begin
            vectors++;
            ad = drdy ? ddata : idata;
            ae = drdy ? derr : ierr;
            if ((u == 1 && q1.size() == 0) || (u == 0 && q0.size() == 0)) begin
                miscompares++;
                $display("FAIL unexpected_rdy dut%0d cyc=%0d: got rdy(D=%0d) data=%h, required none", u, cyc, drdy, ad);
            end else begin
                e = (u == 1) ? q1.pop_front() : q0.pop_front();
                if (e.is_d != drdy || e.data !== ad || e.err !== ae || (e.cyc >= 0 && e.cyc != cyc)) begin
                    miscompares++;
                    $display("FAIL xfer dut%0d: got port_d=%0d data=%h err=%0d cyc=%0d, required port_d=%0d data=%h err=%0d cyc=%0d",
                             u, drdy, ad, ae, cyc, e.is_d, e.data, e.err, e.cyc);
                end else begin
                    $display("dut%0d %s rdy cyc=%0d data=%h err=%0d ok", u, drdy ? "D" : "I", cyc, ad, ae);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(1, bus1.o_IRdy, bus1.o_DRdy, bus1.o_IData, bus1.o_DData, bus1.o_IErr, bus1.o_DErr);
            mon(0, bus0.o_IRdy, bus0.o_DRdy, bus0.o_IData, bus0.o_DData, bus0.o_IErr, bus0.o_DErr);
        end
    end

    task automatic set_req(input int u, input bit is_d, input bit en, input logic [31:0] addr,
                           input bit rnw, input logic [3:0] ben, input logic [31:0] wdata);
        if (u == 1) begin
            if (is_d) begin
                bus1.i_DCmd = en; bus1.i_DAddr = addr; bus1.i_DRnW = rnw; bus1.i_DBen = ben; bus1.i_DData = wdata;
            end else begin
                bus1.i_IRdC = en; bus1.i_IAddr = addr;
            end
        end else begin
            if (is_d) begin
                bus0.i_DCmd = en; bus0.i_DAddr = addr; bus0.i_DRnW = rnw; bus0.i_DBen = ben; bus0.i_DData = wdata;
            end else begin
                bus0.i_IRdC = en; bus0.i_IAddr = addr;
            end
        end
    endtask

    function automatic bit get_rdy(input int u, input bit is_d);
        if (u == 1) return is_d ? bus1.o_DRdy : bus1.o_IRdy;
        return is_d ? bus0.o_DRdy : bus0.o_IRdy;
    endfunction

    // Called just after a rising edge; returns just after the edge following Rdy with the request released.
    task automatic drive_wait(input int u, input bit is_d, input logic [31:0] addr, input bit rnw,
                              input logic [3:0] ben, input logic [31:0] wdata);
        bit seen = 1'b0;
        int k = 0;
        set_req(u, is_d, 1'b1, addr, rnw, ben, wdata);
        while (!seen && k < 64) begin
            @(negedge clk);
            seen = get_rdy(u, is_d);
            k++;
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL timeout dut%0d port_d=%0d addr=%h: got no Rdy in 64 cycles, required Rdy", u, is_d, addr);
        end
        @(posedge clk); #1;
        set_req(u, is_d, 1'b0, addr, rnw, ben, wdata);
    endtask

    task automatic xfer(input int u, input bit is_d, input logic [31:0] addr, input bit rnw,
                        input logic [3:0] ben, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input bit exp_err);
        push_exp(u, is_d, exp_data, exp_err, cyc + 1 + ((u == 1) ? 1 : 0));
        drive_wait(u, is_d, addr, rnw, ben, wdata);
    endtask

    initial begin
        int n;
        set_req(1, 1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
        set_req(0, 1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
        set_req(0, 1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);

        vecs.push_back('{1, 32'h100, 0, 4'hF, 32'hDEADBEEF, 32'h0, 0});
        vecs.push_back('{1, 32'h100, 1, 4'h0, 32'h0, 32'hDEADBEEF, 0});
        vecs.push_back('{1, 32'h104, 0, 4'hF, 32'h11223344, 32'h0, 0});
        vecs.push_back('{1, 32'h104, 0, 4'b0010, 32'h0000AA00, 32'h0, 0});
        vecs.push_back('{1, 32'h104, 1, 4'h0, 32'h0, 32'h1122AA44, 0});
        vecs.push_back('{1, 32'h108, 0, 4'hF, 32'h55AA55AA, 32'h0, 0});
        vecs.push_back('{1, 32'h108, 0, 4'h0, 32'hFFFFFFFF, 32'h0, 0});
        vecs.push_back('{1, 32'h108, 1, 4'h0, 32'h0, 32'h55AA55AA, 0});
        vecs.push_back('{1, 32'h10C, 0, 4'hF, 32'h77777777, 32'h0, 0});
        vecs.push_back('{1, 32'h10C, 0, 4'b1001, 32'h0BADF00D, 32'h0, 0});
        vecs.push_back('{1, 32'h10C, 1, 4'h0, 32'h0, 32'h0B77770D, 0});
        vecs.push_back('{0, 32'h100, 1, 4'h0, 32'h0, 32'hDEADBEEF, 0});
        vecs.push_back('{1, 32'h3FFC, 0, 4'hF, 32'hCAFEF00D, 32'h0, 0});
        vecs.push_back('{0, 32'h3FFC, 1, 4'h0, 32'h0, 32'hCAFEF00D, 0});
        vecs.push_back('{1, 32'h0, 0, 4'hF, 32'hA5A50000, 32'h0, 0});
        vecs.push_back('{1, 32'h102, 1, 4'h0, 32'h0, ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN});
        vecs.push_back('{1, 32'h4000, 1, 4'h0, 32'h0, ERR_EN ? 32'h0 : 32'hA5A50000, ERR_EN});
        vecs.push_back('{1, 32'h4000, 0, 4'hF, 32'h12345678, 32'h0, ERR_EN});
        vecs.push_back('{1, 32'h0, 1, 4'h0, 32'h0, ERR_EN ? 32'hA5A50000 : 32'h12345678, 0});
        vecs.push_back('{1, 32'h3, 0, 4'hF, 32'h00000077, 32'h0, ERR_EN});
        vecs.push_back('{1, 32'h0, 1, 4'h0, 32'h0, ERR_EN ? 32'hA5A50000 : 32'h00000077, 0});
        vecs.push_back('{0, 32'h4000, 1, 4'h0, 32'h0, ERR_EN ? 32'h0 : 32'h00000077, ERR_EN});

        // Reset: every output idle on both instances.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus1.o_IRdy, bus1.o_DRdy, bus1.o_IErr, bus1.o_DErr, bus1.o_IData, bus1.o_DData} !== '0) begin
            miscompares++;
            $display("FAIL reset_out dut1: got IRdy=%b DRdy=%b IErr=%b DErr=%b IData=%h DData=%h, required all 0",
                     bus1.o_IRdy, bus1.o_DRdy, bus1.o_IErr, bus1.o_DErr, bus1.o_IData, bus1.o_DData);
        end
        vectors++;
        if ({bus0.o_IRdy, bus0.o_DRdy, bus0.o_IErr, bus0.o_DErr, bus0.o_IData, bus0.o_DData} !== '0) begin
            miscompares++;
            $display("FAIL reset_out dut0: got IRdy=%b DRdy=%b IErr=%b DErr=%b IData=%h DData=%h, required all 0",
                     bus0.o_IRdy, bus0.o_DRdy, bus0.o_IErr, bus0.o_DErr, bus0.o_IData, bus0.o_DData);
        end
        mon_en = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            xfer(1, vecs[i].is_d, vecs[i].addr, vecs[i].rnw, vecs[i].ben, vecs[i].wdata,
                 vecs[i].exp_data, vecs[i].exp_err);

        // Arbitration: fresh reset leaves last-grant = I, so D wins first and grants alternate.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        n = cyc;
        push_exp(1, 1, 32'hDEADBEEF, 0, n + 2);
        push_exp(1, 0, 32'h0B77770D, 0, n + 5);
        push_exp(1, 1, 32'h1122AA44, 0, n + 8);
        push_exp(1, 0, 32'hDEADBEEF, 0, n + 11);
        push_exp(1, 1, 32'h55AA55AA, 0, n + 14);
        push_exp(1, 0, 32'h1122AA44, 0, n + 17);
        fork
            begin
                drive_wait(1, 1, 32'h100, 1, 4'h0, 32'h0);
                drive_wait(1, 1, 32'h104, 1, 4'h0, 32'h0);
                drive_wait(1, 1, 32'h108, 1, 4'h0, 32'h0);
            end
            begin
                drive_wait(1, 0, 32'h10C, 1, 4'h0, 32'h0);
                drive_wait(1, 0, 32'h100, 1, 4'h0, 32'h0);
                drive_wait(1, 0, 32'h104, 1, 4'h0, 32'h0);
            end
        join

        // Reset during WAIT drops the write and produces no Rdy.
        xfer(1, 1, 32'h200, 0, 4'hF, 32'h11111111, 32'h0, 0);
        set_req(1, 1, 1'b1, 32'h200, 0, 4'hF, 32'h22222222);
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(1, 1, 1'b0, 32'h200, 0, 4'hF, 32'h22222222);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (bus1.o_DRdy || bus1.o_IRdy) begin
                miscompares++;
                $display("FAIL rst_drop cyc=%0d: got DRdy=%b IRdy=%b, required 0", cyc, bus1.o_DRdy, bus1.o_IRdy);
            end
        end
        @(posedge clk); #1;
        xfer(1, 1, 32'h200, 1, 4'h0, 32'h0, 32'h11111111, 0);

        // Zero wait states, non-zero base: last word, Rdy one cycle after accept.
        xfer(0, 1, BASE0 + 32'h3FFC, 0, 4'hF, 32'h600DCAFE, 32'h0, 0);
        xfer(0, 0, BASE0 + 32'h3FFC, 1, 4'h0, 32'h0, 32'h600DCAFE, 0);
        xfer(0, 1, BASE0 - 32'h4, 0, 4'hF, 32'hBAD0BAD0, 32'h0, ERR_EN);
        xfer(0, 1, BASE0 + 32'h3FFC, 1, 4'h0, 32'h0, ERR_EN ? 32'h600DCAFE : 32'hBAD0BAD0, 0);
        if (ERR_EN) xfer(0, 0, BASE0 + 32'h4000, 1, 4'h0, 32'h0, 32'h0, 1);

        repeat (4) @(posedge clk);
        vectors++;
        if (q1.size() != 0 || q0.size() != 0) begin
            miscompares++;
            $display("FAIL pending_exp: got %0d/%0d outstanding, required 0/0", q1.size(), q0.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
